// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, sequencer FSM states and
// default datapath widths used by the shift/rotate unit.
package alu_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_AMT_W = 6;

   // op encodings; 5..7 are illegal and pass the operand through
   localparam logic [2:0] OP_ROL = 3'd0;
   localparam logic [2:0] OP_ROR = 3'd1;
   localparam logic [2:0] OP_SLL = 3'd2;
   localparam logic [2:0] OP_SRL = 3'd3;
   localparam logic [2:0] OP_SRA = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/shift_step.sv
// One step of the shift/rotate datapath (combinational).
//   r    : current working value
//   op   : operation (ROL/ROR/SLL/SRL/SRA; anything else holds r)
//   quad : apply a 4-bit step instead of a 1-bit step
//   nxt  : working value after the step
// Optional feature macro: SHIFT_ROTATE_SEQ_MULTISTEP_EN builds the 4-bit
// path; without it quad is ignored and only 1-bit steps exist.
module shift_step
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] r,
   input  logic [2:0]       op,
   input  logic             quad,
   output logic [WIDTH-1:0] nxt
);

`ifdef SHIFT_ROTATE_SEQ_MULTISTEP_EN
   always_comb begin
      nxt = r;
      if (quad) begin
         case (op)
            OP_ROL:  nxt = {r[WIDTH-5:0], r[WIDTH-1:WIDTH-4]};
            OP_ROR:  nxt = {r[3:0], r[WIDTH-1:4]};
            OP_SLL:  nxt = {r[WIDTH-5:0], 4'b0000};
            OP_SRL:  nxt = {4'b0000, r[WIDTH-1:4]};
            OP_SRA:  nxt = {{4{r[WIDTH-1]}}, r[WIDTH-1:4]};
            default: nxt = r;
         endcase
      end else begin
         case (op)
            OP_ROL:  nxt = {r[WIDTH-2:0], r[WIDTH-1]};
            OP_ROR:  nxt = {r[0], r[WIDTH-1:1]};
            OP_SLL:  nxt = {r[WIDTH-2:0], 1'b0};
            OP_SRL:  nxt = {1'b0, r[WIDTH-1:1]};
            OP_SRA:  nxt = {r[WIDTH-1], r[WIDTH-1:1]};
            default: nxt = r;
         endcase
      end
   end
`else
   wire unused_quad = quad;

   always_comb begin
      nxt = r;
      case (op)
         OP_ROL:  nxt = {r[WIDTH-2:0], r[WIDTH-1]};
         OP_ROR:  nxt = {r[0], r[WIDTH-1:1]};
         OP_SLL:  nxt = {r[WIDTH-2:0], 1'b0};
         OP_SRL:  nxt = {1'b0, r[WIDTH-1:1]};
         OP_SRA:  nxt = {r[WIDTH-1], r[WIDTH-1:1]};
         default: nxt = r;
      endcase
   end
`endif

endmodule

// File: rtl/shift_rotate_seq.sv
// Sequential shift/rotate unit: accepts one op over valid/ready, performs
// it one step per clock, and holds the result until the consumer takes it.
//   clock, reset_n       : clock; synchronous active-low reset
//   in_valid/in_ready    : request handshake (ready only in IDLE)
//   op, a, amt           : operation, operand, amount
//   out_valid/out_ready  : result handshake (valid only in DONE)
//   result, illegal      : result and illegal-op qualifier
//   busy                 : unit is in RUN or DONE
// Optional feature macro: SHIFT_ROTATE_SEQ_MULTISTEP_EN enables 4-bit steps
// while the remaining count is 4 or more.
module shift_rotate_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AMT_W = DEF_AMT_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             illegal,
   output logic             busy
);

   state_e           state, state_nxt;
   logic [WIDTH-1:0] r, r_step;
   logic [2:0]       op_q;
   logic [AMT_W-1:0] cnt, cnt_nxt, n_acc;
   logic             illegal_q;
   logic             legal;
   logic             quad;

   assign legal = (op <= OP_SRA);

   // Step count latched at accept: rotates wrap at WIDTH, shifts saturate
   // at WIDTH (which already produces the fully shifted-out value).
   always_comb begin
      n_acc = '0;
      case (op)
         OP_ROL, OP_ROR:         n_acc = {{(AMT_W-5){1'b0}}, amt[4:0]};
         OP_SLL, OP_SRL, OP_SRA: n_acc = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;
         default:                n_acc = '0;
      endcase
   end

`ifdef SHIFT_ROTATE_SEQ_MULTISTEP_EN
   assign quad = (cnt >= AMT_W'(4));
`else
   assign quad = 1'b0;
`endif

   assign cnt_nxt = cnt - (quad ? AMT_W'(4) : AMT_W'(1));

   shift_step #(.WIDTH(WIDTH)) u_step (
      .r    (r),
      .op   (op_q),
      .quad (quad),
      .nxt  (r_step)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = (n_acc == '0) ? DONE : RUN;
         RUN:     if (cnt_nxt == '0) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         r         <= '0;
         op_q      <= '0;
         cnt       <= '0;
         illegal_q <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (in_valid) begin
               r         <= a;
               op_q      <= op;
               cnt       <= n_acc;
               illegal_q <= !legal;
            end
            RUN: begin
               r   <= r_step;
               cnt <= cnt_nxt;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = reset_n && (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign result    = r;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Scoreboard bench for shift_rotate_seq: a driver issues ops and pushes the
// expected result into a queue; a monitor pops on each new out_valid.
module tb_shift_rotate_seq;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = '0;
   logic [31:0] a = '0;
   logic [5:0]  amt = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        illegal;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      logic        ill;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   seen = 0;
   bit   force_low = 0;
   bit   force_high = 0;

   shift_rotate_seq dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .amt       (amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .illegal   (illegal),
      .busy      (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference model from the operation definitions, not the step datapath.
   function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input int m);
      exp_t e;
      int n;
      logic [63:0] d;
      e.ill = 1'b0;
      e.res = x;
      n = 0;
      d = {x, x};
      case (o)
         3'd0: begin n = m % 32; d = d << n; e.res = d[63:32]; end
         3'd1: begin n = m % 32; d = d >> n; e.res = d[31:0]; end
         3'd2: begin n = (m > 32) ? 32 : m; e.res = (n >= 32) ? 32'h0 : x << n; end
         3'd3: begin n = (m > 32) ? 32 : m; e.res = (n >= 32) ? 32'h0 : x >> n; end
         3'd4: begin n = (m > 32) ? 32 : m; e.res = $signed(x) >>> ((n > 31) ? 31 : n); end
         default: begin n = 0; e.ill = 1'b1; end
      endcase
`ifdef SHIFT_ROTATE_SEQ_MULTISTEP_EN
      e.lat = n / 4 + n % 4;
`else
      e.lat = n;
`endif
      e.acc = 0;
      return e;
   endfunction

   // out_ready policy: random unless a test pins it
   initial forever begin
      @(negedge clock);
      if (force_low) out_ready = 1'b0;
      else if (force_high) out_ready = 1'b1;
      else out_ready = ($urandom_range(3) != 0);
   end

   // Monitor: first cycle of each out_valid pops the scoreboard; later
   // cycles of the same result check that it stays stable.
   always @(negedge clock) begin
      if (!reset_n) begin
         seen = 0;
      end else if (out_valid) begin
         if (!seen) begin
            seen = 1;
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_out_valid: result %h with empty scoreboard", result);
            end else begin
               cur = sb.pop_front();
               chk("result", result, cur.res);
               chk("illegal", {31'b0, illegal}, {31'b0, cur.ill});
               chk("latency", cyc - cur.acc, cur.lat);
            end
         end else begin
            chk("result_stable", result, cur.res);
         end
      end else begin
         seen = 0;
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [5:0] m);
      exp_t e;
      int t;
      t = 0;
      @(negedge clock);
      while (!in_ready && t < 200) begin @(negedge clock); t++; end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL in_ready_timeout: in_ready %b expected 1", in_ready);
         return;
      end
      op = o; a = x; amt = m; in_valid = 1'b1;
      e = model(o, x, int'(m));
      @(posedge clock);
      #1;
      e.acc = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
      op = $urandom; a = $urandom; amt = $urandom;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || busy) && t < 500) begin @(negedge clock); t++; end
      total++;
      if (sb.size() != 0 || busy) begin
         bad++;
         $display("FAIL drain_timeout: pending %0d busy %b expected 0 0", sb.size(), busy);
      end
   endtask

   initial begin
      int t;
      // reset state
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);
      reset_n = 1'b1;
      #1;
      chk("rst_release_ready", {31'b0, in_ready}, 32'd1);

      // directed cases
      force_high = 1;
      issue(3'd0, 32'h1, 6'd3);
      issue(3'd1, 32'h1, 6'd3);
      issue(3'd0, 32'h80000000, 6'd1);
      issue(3'd0, 32'h12345678, 6'd32);
      issue(3'd4, 32'h80000000, 6'd40);
      issue(3'd3, 32'h80000000, 6'd40);
      issue(3'd2, 32'h1, 6'd63);
      issue(3'd6, 32'hDEADBEEF, 6'd17);
      issue(3'd1, 32'hCAFEF00D, 6'd0);
      drain();
      force_high = 0;

      // backpressure: result held with out_ready low
      force_low = 1;
      @(negedge clock);
      out_ready = 1'b0;
      issue(3'd1, 32'hF, 6'd4);
      t = 0;
      while (!out_valid && t < 100) begin @(negedge clock); t++; end
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_result", result, 32'hF0000000);
         chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      end
      force_low = 0; force_high = 1;
      out_ready = 1'b1;
      @(negedge clock);
      chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
      chk("bp_release_busy", {31'b0, busy}, 32'd0);
      force_high = 0;

      // reset mid-RUN discards the operation
      force_high = 1;
      issue(3'd2, 32'h1, 6'd20);
      repeat (4) @(negedge clock);
      reset_n = 1'b0;
      sb.delete();
      @(negedge clock);
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_result", result, 32'h0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      reset_n = 1'b1;
      #1;
      chk("midrst_ready", {31'b0, in_ready}, 32'd1);
      op = 3'd0; a = 32'h00000003; amt = 6'd2; in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      chk("post_rst_accept_busy", {31'b0, busy}, 32'd1);
      begin
         exp_t e;
         e = model(3'd0, 32'h3, 2);
         e.acc = cyc;
         sb.push_back(e);
      end
      drain();
      force_high = 0;

      // random traffic with random backpressure
      for (int i = 0; i < 60; i++) begin
         logic [5:0] m;
         m = (i % 3 == 0) ? 6'($urandom_range(30, 40)) : 6'($urandom);
         issue(3'($urandom_range(7)), $urandom, m);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global safety net
   initial begin
      #400000;
      $display("FAIL global_timeout: cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_rotate_seq.md
Name: shift_rotate_seq

Overview:
- Sequential shift/rotate execution unit for the ALU; sits between the operand/decode stage and the ALU result writeback.
- Accepts one operation over a valid/ready handshake, performs it one bit-step per clock, and holds the result until the consumer takes it.
- Gives the rotate datapath an explicit done/backpressure protocol, replacing the bare start pulse and fixed wait time.

Parameters:
- WIDTH, 32, data width; must be 32 in this revision.
- AMT_W, 6, shift-amount width.

Ports:
- clock  input  1  system clock; all state updates on posedge
- reset_n  input  1  synchronous active-low reset, sampled on posedge clock
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept an operation (high only in IDLE)
- op  input  3  0=ROL, 1=ROR, 2=SLL, 3=SRL, 4=SRA, 5..7 illegal
- a  input  WIDTH  operand
- amt  input  AMT_W  shift/rotate amount
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result, stable while out_valid
- illegal  output  1  qualifies result; op was 5..7
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: one clock edge with reset_n=0 gives state=IDLE; result, illegal, out_valid and busy all 0. in_ready is 0 while reset_n=0. Reset overrides everything, including mid-RUN and DONE; an in-flight operation is discarded with no output.
- Step count n is latched at accept:
  - ROL/ROR: n = amt[4:0].
  - SLL/SRL/SRA: n = min(amt, 32).
  - Illegal op: n = 0.
- Accept occurs on an edge where state=IDLE and in_valid=1. At that edge the unit latches a into the working register, latches op and n, and sets illegal.
  - n=0: go to DONE; result = a.
  - n>0: go to RUN.
- RUN: each edge applies one 1-bit step and decrements the counter. The edge that applies the final step goes to DONE. out_valid rises after exactly n edges following the accept edge (n=0: 0 edges, so out_valid is high the cycle after accept).
- Step definitions:
  - ROL: {r[30:0], r[31]}
  - ROR: {r[0], r[31:1]}
  - SLL: {r[30:0], 0}
  - SRL: {0, r[31:1]}
  - SRA: {r[31], r[31:1]}
  - Consequences: a shift of 32 or more gives 0 (SLL/SRL) or a replicated sign (SRA); a rotate by 32 gives a.
- DONE: result and illegal are held constant. An edge with out_ready=1 returns the unit to IDLE.
  - in_ready is low in DONE, so there is no accept in the same cycle. The earliest next accept is the edge after the return to IDLE.
  - result keeps its last value in IDLE. Only out_valid qualifies it.
- Handshake rules:
  - in_valid and inputs are ignored outside IDLE.
  - The consumer may hold out_ready low indefinitely; the unit stalls.
  - out_ready is ignored outside DONE.
- busy = (state != IDLE).

Optional Feature:
- Macro: SHIFT_ROTATE_SEQ_MULTISTEP_EN
- Defined:
  - In RUN, if the counter is 4 or more, apply a 4-bit step of the same op and subtract 4; otherwise apply a 1-bit step.
  - Latency in RUN becomes floor(n/4) + (n mod 4) edges.
  - Results are identical to the 1-bit mode.
- Undefined: 1-bit step every RUN cycle only; the 4-bit datapath is absent.

Decomposition:
- Shared package alu_pkg:
  - op encodings: OP_ROL=0, OP_ROR=1, OP_SLL=2, OP_SRL=3, OP_SRA=4.
  - FSM state encoding: IDLE=0, RUN=1, DONE=2.
  - WIDTH/AMT_W defaults.
- Sub-module shift_step: combinational; inputs r, op, and a 4-step select; output is the next r. It isolates the step datapath from the FSM/counter/handshake logic in shift_rotate_seq.

Test Plan:
- ROL a=1, amt=3, out_ready=1 -> out_valid 3 edges after accept, result=0x00000008, illegal=0.
- ROR a=1, amt=3 -> result=0x20000000. ROL a=0x80000000, amt=1 -> result=0x00000001. ROL a=0x12345678, amt=32 -> result=0x12345678 with out_valid the cycle after accept.
- SRA a=0x80000000, amt=40 -> 32 RUN edges, result=0xFFFFFFFF. SRL same operands -> result=0x00000000.
- Backpressure: ROR a=0xF, amt=4, out_ready=0 for 10 cycles -> out_valid held, result=0xF0000000 stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
- Illegal op=6, a=0xDEADBEEF -> out_valid the cycle after accept, result=0xDEADBEEF, illegal=1.
- reset_n=0 for one edge mid-RUN (SLL a=1, amt=20, after 5 steps) -> IDLE, out_valid=0, result=0, busy=0. A new op is accepted on the first edge after reset_n=1.
